// File: rtl/nmc_req_dispatch.sv
// Host command dispatcher in front of nmc: splits commands into write/query FIFO pushes,
// tracks queries in flight against MAX_OUTSTAND and implements a fence that drains them.
module nmc_req_dispatch #(
  parameter int ADDR_WIDTH    = 8,
  parameter int ID_WIDTH      = 8,
  parameter int FEATURE_WIDTH = 32,
  parameter int RESULT_WIDTH  = 32,
  parameter int MAX_OUTSTAND  = 8,
  localparam int OW           = $clog2(MAX_OUTSTAND + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ADDR_WIDTH-1:0]    cmd_wr_addr,
  input  logic [ID_WIDTH-1:0]      cmd_wr_id,
  input  logic [FEATURE_WIDTH-1:0] cmd_wr_feat,
  input  logic [RESULT_WIDTH-1:0]  cmd_wr_res,
  input  logic [ADDR_WIDTH-1:0]    cmd_qr_addr,
  input  logic [FEATURE_WIDTH-1:0] cmd_qr_feat,
  output logic                     nwr_push,
  output logic [ADDR_WIDTH-1:0]    nwr_addr,
  output logic [ID_WIDTH-1:0]      nwr_id,
  output logic [FEATURE_WIDTH-1:0] nwr_feat,
  output logic [RESULT_WIDTH-1:0]  nwr_res,
  input  logic                     nwr_full,
  output logic                     nqr_push,
  output logic [ADDR_WIDTH-1:0]    nqr_addr,
  output logic [FEATURE_WIDTH-1:0] nqr_feat,
  input  logic                     nqr_full,
  input  logic                     resp_valid,
  output logic [OW-1:0]            outstanding,
  output logic                     busy,
  output logic                     err_underflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, FENCE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
  logic [ID_WIDTH-1:0]      wr_id_q, wr_id_d;
  logic [FEATURE_WIDTH-1:0] wr_feat_q, wr_feat_d;
  logic [RESULT_WIDTH-1:0]  wr_res_q, wr_res_d;
  logic [ADDR_WIDTH-1:0]    qr_addr_q, qr_addr_d;
  logic [FEATURE_WIDTH-1:0] qr_feat_q, qr_feat_d;
  logic                     wr_pend_q, wr_pend_d;
  logic                     qr_pend_q, qr_pend_d;
  logic [OW-1:0]            outst_q, outst_d;
  logic                     err_q, err_d;
  logic                     qr_room;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wr_id_q   <= '0;
      wr_feat_q <= '0;
      wr_res_q  <= '0;
      qr_addr_q <= '0;
      qr_feat_q <= '0;
      wr_pend_q <= 1'b0;
      qr_pend_q <= 1'b0;
      outst_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_id_q   <= wr_id_d;
      wr_feat_q <= wr_feat_d;
      wr_res_q  <= wr_res_d;
      qr_addr_q <= qr_addr_d;
      qr_feat_q <= qr_feat_d;
      wr_pend_q <= wr_pend_d;
      qr_pend_q <= qr_pend_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
    end
  end

  assign qr_room = (outst_q < OW'(MAX_OUTSTAND));

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_id_d   = wr_id_q;
    wr_feat_d = wr_feat_q;
    wr_res_d  = wr_res_q;
    qr_addr_d = qr_addr_q;
    qr_feat_d = qr_feat_q;
    wr_pend_d = wr_pend_q;
    qr_pend_d = qr_pend_q;
    cmd_ready = 1'b0;
    nwr_push  = 1'b0;
    nqr_push  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) begin
          wr_addr_d = cmd_wr_addr;
          wr_id_d   = cmd_wr_id;
          wr_feat_d = cmd_wr_feat;
          wr_res_d  = cmd_wr_res;
          qr_addr_d = cmd_qr_addr;
          qr_feat_d = cmd_qr_feat;
          wr_pend_d = cmd_op[0];
          qr_pend_d = cmd_op[1];
          state_d   = (cmd_op == 2'b00) ? FENCE : ISSUE;
        end
      end
      ISSUE: begin
        // Write and query sides drain independently; leave once both are done.
        nwr_push  = wr_pend_q & !nwr_full;
        nqr_push  = qr_pend_q & !nqr_full & qr_room;
        wr_pend_d = wr_pend_q & !nwr_push;
        qr_pend_d = qr_pend_q & !nqr_push;
        if (!wr_pend_d && !qr_pend_d) state_d = IDLE;
      end
      FENCE: begin
        if (outst_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    err_d   = err_q | (resp_valid & (outst_q == '0));
    // A response with nothing in flight is an error and must not wrap the counter.
    case ({nqr_push, resp_valid})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   if (outst_q != '0) outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
  end

  assign nwr_addr      = wr_addr_q;
  assign nwr_id        = wr_id_q;
  assign nwr_feat      = wr_feat_q;
  assign nwr_res       = wr_res_q;
  assign nqr_addr      = qr_addr_q;
  assign nqr_feat      = qr_feat_q;
  assign outstanding   = outst_q;
  assign busy          = (state_q != IDLE);
  assign err_underflow = err_q;

endmodule

// File: tb/tb_nmc_req_dispatch.sv
// Directed bench for nmc_req_dispatch with a push scoreboard and immediate-assertion checks.
module tb_nmc_req_dispatch;

  localparam int MAXO = 3;
  localparam int OW   = $clog2(MAXO + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_wr_addr, cmd_wr_id, cmd_qr_addr;
  logic [31:0] cmd_wr_feat, cmd_wr_res, cmd_qr_feat;
  logic        nwr_push, nqr_push, nwr_full, nqr_full, resp_valid;
  logic [7:0]  nwr_addr, nwr_id, nqr_addr;
  logic [31:0] nwr_feat, nwr_res, nqr_feat;
  logic [OW-1:0] outstanding;
  logic        busy, err_underflow;

  int tests = 0;
  int failed = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  id;
    logic [31:0] feat;
    logic [31:0] res;
  } wr_rec_t;
  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] feat;
  } qr_rec_t;

  wr_rec_t wr_sb[$];
  qr_rec_t qr_sb[$];

  nmc_req_dispatch #(
    .ADDR_WIDTH(8), .ID_WIDTH(8), .FEATURE_WIDTH(32), .RESULT_WIDTH(32), .MAX_OUTSTAND(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wr_addr(cmd_wr_addr), .cmd_wr_id(cmd_wr_id), .cmd_wr_feat(cmd_wr_feat),
    .cmd_wr_res(cmd_wr_res), .cmd_qr_addr(cmd_qr_addr), .cmd_qr_feat(cmd_qr_feat),
    .nwr_push(nwr_push), .nwr_addr(nwr_addr), .nwr_id(nwr_id), .nwr_feat(nwr_feat),
    .nwr_res(nwr_res), .nwr_full(nwr_full), .nqr_push(nqr_push), .nqr_addr(nqr_addr),
    .nqr_feat(nqr_feat), .nqr_full(nqr_full), .resp_valid(resp_valid),
    .outstanding(outstanding), .busy(busy), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge, i.e. in the first cycle a push may appear.
  task automatic send(input logic [1:0] op, input logic [7:0] wa, input logic [7:0] wid,
                      input logic [31:0] wf, input logic [31:0] wr, input logic [7:0] qa,
                      input logic [31:0] qf, input bit sb);
    bit ok = 1'b0;
    cmd_op = op; cmd_wr_addr = wa; cmd_wr_id = wid; cmd_wr_feat = wf; cmd_wr_res = wr;
    cmd_qr_addr = qa; cmd_qr_feat = qf; cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", {127'd0, ok}, 128'd1);
    if (ok && sb && op[0]) wr_sb.push_back('{addr: wa, id: wid, feat: wf, res: wr});
    if (ok && sb && op[1]) qr_sb.push_back('{addr: qa, feat: qf});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic respond();
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (nwr_push) begin
      check("wr_sb_nonempty", {127'd0, wr_sb.size() != 0}, 128'd1);
      if (wr_sb.size() != 0) check("wr_fields", {nwr_addr, nwr_id, nwr_feat, nwr_res}, wr_sb.pop_front());
    end
    if (nqr_push) begin
      check("qr_sb_nonempty", {127'd0, qr_sb.size() != 0}, 128'd1);
      if (qr_sb.size() != 0) check("qr_fields", {nqr_addr, nqr_feat}, qr_sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_wr_addr = '0; cmd_wr_id = '0;
    cmd_wr_feat = '0; cmd_wr_res = '0; cmd_qr_addr = '0; cmd_qr_feat = '0;
    nwr_full = 1'b0; nqr_full = 1'b0; resp_valid = 1'b0;
    #1;
    check("rst_push", {nwr_push, nqr_push}, 2'b00);
    check("rst_outst", outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_underflow, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rel_ready", cmd_ready, 1);

    // T2: write+query with both FIFOs free
    send(2'b11, 8'h05, 8'h11, 32'h1234_5678, 32'hCAFE_0001, 8'h22, 32'hDEAD_BEEF, 1'b1);
    check("t2_push", {nwr_push, nqr_push}, 2'b11);
    check("t2_wr_addr", nwr_addr, 8'h05);
    check("t2_qr_feat", nqr_feat, 32'hDEAD_BEEF);
    check("t2_ready_n1", cmd_ready, 0);
    tick();
    check("t2_outst", outstanding, 1);
    check("t2_ready_n2", cmd_ready, 1);
    check("t2_busy_n2", busy, 0);
    respond();
    check("t2_outst_ret", outstanding, 0);

    // T3: write FIFO full for three cycles
    nwr_full = 1'b1;
    send(2'b11, 8'h31, 8'h32, 32'h3333_0000, 32'h3333_1111, 8'h34, 32'h3535_3535, 1'b1);
    check("t3_push_n1", {nwr_push, nqr_push}, 2'b01);
    tick();
    check("t3_push_n2", {nwr_push, nqr_push}, 2'b00);
    check("t3_busy_n2", busy, 1);
    tick();
    check("t3_push_n3", {nwr_push, nqr_push}, 2'b00);
    check("t3_hold", {nwr_addr, nwr_feat}, {8'h31, 32'h3333_0000});
    tick();
    nwr_full = 1'b0;
    #1;
    check("t3_push_n4", {nwr_push, nqr_push}, 2'b10);
    tick();
    check("t3_idle", {busy, cmd_ready}, 2'b01);
    respond();
    check("t3_outst_ret", outstanding, 0);

    // T4: outstanding limit holds the next query
    for (int i = 0; i < MAXO; i++)
      send(2'b10, 8'h00, 8'h00, 32'h0, 32'h0, 8'h40 + 8'(i), 32'h4000_0000 + 32'(i), 1'b1);
    send(2'b10, 8'h00, 8'h00, 32'h0, 32'h0, 8'h4F, 32'h4FFF_FFFF, 1'b1);
    check("t4_full_outst", outstanding, MAXO);
    check("t4_stall_n1", nqr_push, 0);
    tick();
    check("t4_stall_n2", {nqr_push, busy}, 2'b01);
    respond();
    check("t4_outst_dec", outstanding, MAXO - 1);
    check("t4_push_after", nqr_push, 1);
    tick();
    check("t4_outst_back", outstanding, MAXO);
    check("t4_idle", cmd_ready, 1);

    // T5: fence waits for all outstanding queries
    send(2'b00, 8'h0, 8'h0, 32'h0, 32'h0, 8'h0, 32'h0, 1'b0);
    check("t5_busy", {busy, cmd_ready}, 2'b10);
    for (int i = 0; i < MAXO; i++) begin
      respond();
      check("t5_fence_hold", {busy, cmd_ready}, 2'b10);
    end
    check("t5_outst0", outstanding, 0);
    tick();
    check("t5_idle", {busy, cmd_ready}, 2'b01);

    // T6: underflow, then simultaneous push and response
    respond();
    check("t6_err", err_underflow, 1);
    check("t6_outst0", outstanding, 0);
    send(2'b10, 8'h0, 8'h0, 32'h0, 32'h0, 8'h61, 32'h6161_6161, 1'b1);
    tick();
    check("t6_outst1", outstanding, 1);
    send(2'b10, 8'h0, 8'h0, 32'h0, 32'h0, 8'h62, 32'h6262_6262, 1'b1);
    check("t6_push", nqr_push, 1);
    respond();
    check("t6_outst_same", outstanding, 1);
    check("t6_err_sticky", err_underflow, 1);

    // T1: reset in the middle of a stalled write
    nwr_full = 1'b1;
    send(2'b01, 8'h71, 8'h72, 32'h7373_7373, 32'h7474_7474, 8'h0, 32'h0, 1'b0);
    check("t1_stalled", {busy, nwr_push}, 2'b10);
    nwr_full = 1'b0;
    rst = 1'b1;
    #1;
    check("t1_push_off", {nwr_push, nqr_push}, 2'b00);
    check("t1_regs_zero", {nwr_addr, nwr_feat}, 40'd0);
    check("t1_busy", busy, 0);
    check("t1_err_clr", err_underflow, 0);
    tick();
    rst = 1'b0;
    #1;
    check("t1_ready", cmd_ready, 1);
    check("t1_outst", outstanding, 0);
    tick(); tick();
    check("t1_no_push", {nwr_push, nqr_push, busy}, 3'b000);

    check("sb_wr_empty", wr_sb.size(), 0);
    check("sb_qr_empty", qr_sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
